// File: rtl/serv_trace_pkg.sv
// Shared constants for the SERV retirement trace buffer: FSM encoding and record layout.
package serv_trace_pkg;

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_RUN  = 2'b01;
   localparam logic [1:0] ST_POST = 2'b10;
   localparam logic [1:0] ST_STOP = 2'b11;

   localparam int unsigned REC_W       = 102;
   localparam int unsigned PC_LSB      = 0;
   localparam int unsigned INSN_LSB    = 32;
   localparam int unsigned RD_DATA_LSB = 64;
   localparam int unsigned RD_ADDR_LSB = 96;
   localparam int unsigned RD_WE_BIT   = 101;

endpackage

// File: rtl/serv_trace_fifo.sv
// Circular record store with optional overwrite of the oldest entry when full.
module serv_trace_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned REC_W = 102,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             push,
   input  logic             pop,
   input  logic             ovw_en,
   input  logic [REC_W-1:0] wdata,
   output logic [REC_W-1:0] rdata_c,
   output logic [AW:0]      level,
   output logic             valid,
   output logic             full
);

   logic [REC_W-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      level_nxt;
   logic             pop_ok;
   logic             wr_ok;
   logic             drop_old;

   // A simultaneous pop frees the slot, so a push into a full buffer only evicts without a pop.
   always_comb begin
      pop_ok    = pop & valid;
      wr_ok     = push & (~full | pop_ok | ovw_en);
      drop_old  = push & full & ~pop_ok & ovw_en;
      level_nxt = level;
      if (clr)
         level_nxt = '0;
      else if (wr_ok && !pop_ok && !drop_old)
         level_nxt = level + 1'b1;
      else if (pop_ok && !wr_ok)
         level_nxt = level - 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         valid  <= 1'b0;
         full   <= 1'b0;
      end else begin
         level <= level_nxt;
         valid <= (level_nxt != '0);
         full  <= (level_nxt == (AW+1)'(DEPTH));
         if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (wr_ok)
               wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok || drop_old)
               rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok && !clr)
         mem[wr_ptr] <= wdata;
   end

   assign rdata_c = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/serv_trace_buf.sv
// Retirement trace buffer: deserialises rd writeback, tracks PC and packs one record per retire.
module serv_trace_buf
   import serv_trace_pkg::*;
#(
   parameter int unsigned W        = 1,
   parameter int unsigned DEPTH    = 16,
   parameter logic [31:0] RESET_PC = 32'h0,
   parameter int unsigned B        = W - 1,
   parameter int unsigned AW       = $clog2(DEPTH)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_ibus_ack,
   input  logic [31:0]      i_ibus_rdt,
   input  logic [31:0]      i_ibus_adr,
   input  logic             i_cnt_done,
   input  logic             i_ctrl_pc_en,
   input  logic             i_wen0,
   input  logic [B:0]       i_wdata0,
   input  logic [4:0]       i_rd_addr,
   input  logic             i_arm,
   input  logic             i_abort,
   input  logic             i_trig_en,
   input  logic [31:0]      i_trig_pc,
   input  logic [AW-1:0]    i_post_cnt,
   output logic             o_rd_valid,
   input  logic             i_rd_ready,
   output logic [REC_W-1:0] o_rd_data,
   output logic [AW:0]      o_level,
   output logic [1:0]       o_state,
   output logic             o_triggered,
   output logic             o_overflow
);

   localparam logic [AW:0] LVL_LAST = (AW+1)'(DEPTH - 1);

   logic [31:0]      insn_q, rd_sh, rd_sh_nxt, adr_q, pc_cur, tpc_q, tpc_nxt;
   logic             rd_flag, flag_nxt, commit_q, retire;
   logic [REC_W-1:0] rec;
   logic [1:0]       state, state_nxt;
   logic             mode_q, mode_nxt, trig_nxt, ovf_nxt;
   logic [AW-1:0]    post_q, post_nxt, cnt_q, cnt_nxt;
   logic             push, clr, pop, full;

   assign retire = i_cnt_done & i_ctrl_pc_en;
   assign pop    = o_rd_valid & i_rd_ready;

   // Commit clears the shifter; a chunk arriving in the same cycle starts the next instruction.
   always_comb begin
      rd_sh_nxt = commit_q ? 32'h0 : rd_sh;
      flag_nxt  = commit_q ? 1'b0 : rd_flag;
      if (i_wen0) begin
         rd_sh_nxt = (32'(i_wdata0) << (32 - W)) | (rd_sh_nxt >> W);
         flag_nxt  = 1'b1;
      end
   end

   always_comb begin
      rec                         = '0;
      rec[PC_LSB +: 32]           = pc_cur;
      rec[INSN_LSB +: 32]         = insn_q;
      rec[RD_DATA_LSB +: 32]      = rd_sh;
      rec[RD_ADDR_LSB +: 5]       = i_rd_addr;
      rec[RD_WE_BIT]              = rd_flag & (i_rd_addr != 5'd0);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         insn_q   <= 32'h0;
         rd_sh    <= 32'h0;
         rd_flag  <= 1'b0;
         commit_q <= 1'b0;
         adr_q    <= 32'h0;
         pc_cur   <= RESET_PC;
      end else begin
         if (i_ibus_ack)
            insn_q <= i_ibus_rdt;
         rd_sh    <= rd_sh_nxt;
         rd_flag  <= flag_nxt;
         commit_q <= retire;
         if (retire)
            adr_q <= i_ibus_adr;
         if (commit_q)
            pc_cur <= adr_q;
      end
   end

   // post_cnt is AW bits wide, so it never exceeds DEPTH-1 and the trigger record always survives.
   always_comb begin
      state_nxt = state;
      mode_nxt  = mode_q;
      tpc_nxt   = tpc_q;
      post_nxt  = post_q;
      cnt_nxt   = cnt_q;
      trig_nxt  = o_triggered;
      ovf_nxt   = o_overflow;
      push      = 1'b0;
      clr       = 1'b0;
      if (i_arm) begin
         clr       = 1'b1;
         state_nxt = ST_RUN;
         trig_nxt  = 1'b0;
         ovf_nxt   = 1'b0;
         mode_nxt  = i_trig_en;
         tpc_nxt   = i_trig_pc;
         post_nxt  = i_post_cnt;
      end else if (i_abort && state != ST_IDLE) begin
         state_nxt = ST_STOP;
      end else if (commit_q) begin
         case (state)
            ST_RUN: begin
               push = 1'b1;
               if (!mode_q) begin
                  if (o_level == LVL_LAST && !pop)
                     state_nxt = ST_STOP;
               end else if (pc_cur == tpc_q) begin
                  trig_nxt  = 1'b1;
                  cnt_nxt   = post_q;
                  state_nxt = (post_q == '0) ? ST_STOP : ST_POST;
               end
            end
            ST_POST: begin
               push    = 1'b1;
               cnt_nxt = cnt_q - 1'b1;
               if (cnt_q == AW'(1))
                  state_nxt = ST_STOP;
            end
            default: ;
         endcase
         if (push && full && !pop)
            ovf_nxt = 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= ST_IDLE;
         mode_q      <= 1'b0;
         tpc_q       <= 32'h0;
         post_q      <= '0;
         cnt_q       <= '0;
         o_triggered <= 1'b0;
         o_overflow  <= 1'b0;
      end else begin
         state       <= state_nxt;
         mode_q      <= mode_nxt;
         tpc_q       <= tpc_nxt;
         post_q      <= post_nxt;
         cnt_q       <= cnt_nxt;
         o_triggered <= trig_nxt;
         o_overflow  <= ovf_nxt;
      end
   end

   assign o_state = state;

   serv_trace_fifo #(
      .DEPTH (DEPTH),
      .REC_W (REC_W),
      .AW    (AW)
   ) u_fifo (
      .clk     (i_clk),
      .rst_n   (i_rst_n),
      .clr     (clr),
      .push    (push),
      .pop     (pop),
      .ovw_en  (mode_q),
      .wdata   (rec),
      .rdata_c (o_rd_data),
      .level   (o_level),
      .valid   (o_rd_valid),
      .full    (full)
   );

endmodule

// File: tb/tb_serv_trace_buf.sv
// Scoreboard bench for serv_trace_buf: a queue model tracks expected records and status.
module tb_serv_trace_buf;

   localparam int unsigned TW  = 4;
   localparam int unsigned TD  = 4;
   localparam int unsigned TAW = 2;
   localparam logic [31:0] RPC = 32'h0;
   localparam logic [1:0]  S_IDLE = 2'b00, S_RUN = 2'b01, S_POST = 2'b10, S_STOP = 2'b11;

   typedef logic [101:0] rec_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          ibus_ack, cnt_done, ctrl_pc_en, wen0, arm, abort, trig_en, rd_ready;
   logic [31:0]   ibus_rdt, ibus_adr, trig_pc;
   logic [TW-1:0] wdata0;
   logic [4:0]    rd_addr;
   logic [TAW-1:0] post_cnt;
   logic          rd_valid, triggered, overflow;
   logic [101:0]  rd_data;
   logic [TAW:0]  level;
   logic [1:0]    state;

   rec_t        mq[$];
   logic [1:0]  m_state;
   bit          m_mode, m_trig, m_ovf;
   logic [31:0] m_tpc, m_pc;
   int          m_post, m_cnt;
   int          n_tests = 0;
   int          n_fail  = 0;

   always #5 clk = ~clk;

   serv_trace_buf #(.W(TW), .DEPTH(TD), .RESET_PC(RPC)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_ibus_ack(ibus_ack), .i_ibus_rdt(ibus_rdt),
      .i_ibus_adr(ibus_adr), .i_cnt_done(cnt_done), .i_ctrl_pc_en(ctrl_pc_en),
      .i_wen0(wen0), .i_wdata0(wdata0), .i_rd_addr(rd_addr), .i_arm(arm),
      .i_abort(abort), .i_trig_en(trig_en), .i_trig_pc(trig_pc), .i_post_cnt(post_cnt),
      .o_rd_valid(rd_valid), .i_rd_ready(rd_ready), .o_rd_data(rd_data),
      .o_level(level), .o_state(state), .o_triggered(triggered), .o_overflow(overflow)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_status(input string tag);
      check({tag, ".state"}, 128'(state), 128'(m_state));
      check({tag, ".level"}, 128'(level), 128'(mq.size()));
      check({tag, ".valid"}, 128'(rd_valid), 128'(mq.size() != 0));
      check({tag, ".trig"},  128'(triggered), 128'(m_trig));
      check({tag, ".ovf"},   128'(overflow), 128'(m_ovf));
   endtask

   function automatic logic [31:0] addi(input logic [4:0] rd, input logic [11:0] imm);
      return {imm, 5'd0, 3'b000, rd, 7'h13};
   endfunction

   task automatic model_commit(input rec_t r);
      if (m_state == S_RUN || m_state == S_POST) begin
         if (mq.size() == TD) begin
            void'(mq.pop_front());
            m_ovf = 1'b1;
         end
         mq.push_back(r);
         if (m_state == S_RUN) begin
            if (!m_mode) begin
               if (mq.size() == TD) m_state = S_STOP;
            end else if (r[31:0] == m_tpc) begin
               m_trig = 1'b1;
               if (m_post == 0) m_state = S_STOP;
               else begin m_cnt = m_post; m_state = S_POST; end
            end
         end else begin
            m_cnt--;
            if (m_cnt == 0) m_state = S_STOP;
         end
      end
   endtask

   // One instruction: fetch, 32/TW writeback chunks with retire on the last, then the commit cycle.
   task automatic retire(input logic [31:0] insn, input logic [4:0] rd, input bit wr,
                         input logic [31:0] data, input logic [31:0] nxt, input bit pop);
      rec_t r;
      @(negedge clk);
      ibus_ack = 1'b1; ibus_rdt = insn; rd_addr = rd;
      for (int k = 0; k < 32 / TW; k++) begin
         @(negedge clk);
         ibus_ack = 1'b0; ibus_rdt = $urandom; wen0 = wr;
         wdata0 = TW'(data >> (k * TW));
         if (k == 32 / TW - 1) begin
            cnt_done = 1'b1; ctrl_pc_en = 1'b1; ibus_adr = nxt;
         end else begin
            ctrl_pc_en = 1'($urandom_range(0, 1));
         end
      end
      @(negedge clk);
      wen0 = 1'b0; cnt_done = 1'b0; ctrl_pc_en = 1'b0; ibus_adr = $urandom;
      if (pop) begin
         check("pop_data", 128'(rd_data), (mq.size() != 0) ? 128'(mq[0]) : 128'h0);
         rd_ready = 1'b1;
         if (mq.size() != 0) void'(mq.pop_front());
      end
      r = {wr && (rd != 5'd0), rd, wr ? data : 32'h0, insn, m_pc};
      model_commit(r);
      m_pc = nxt;
      @(negedge clk);
      rd_ready = 1'b0;
   endtask

   task automatic do_arm(input bit te, input logic [31:0] tpc, input int post);
      @(negedge clk);
      arm = 1'b1; trig_en = te; trig_pc = tpc; post_cnt = TAW'(post);
      @(negedge clk);
      arm = 1'b0;
      mq.delete();
      m_state = S_RUN; m_trig = 1'b0; m_ovf = 1'b0;
      m_mode = te; m_tpc = tpc; m_post = post;
      check_status("arm");
   endtask

   task automatic do_abort();
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      if (m_state != S_IDLE) m_state = S_STOP;
      check_status("abort");
   endtask

   task automatic drain(input string tag);
      int n;
      n = mq.size();
      for (int i = 0; i < n; i++) begin
         check({tag, ".dvalid"}, 128'(rd_valid), 128'(1));
         check({tag, ".drec"}, 128'(rd_data), 128'(mq[0]));
         rd_ready = 1'b1;
         void'(mq.pop_front());
         @(negedge clk);
      end
      rd_ready = 1'b0;
      check({tag, ".empty_valid"}, 128'(rd_valid), 128'(0));
      check({tag, ".empty_data"}, 128'(rd_data), 128'(0));
      check({tag, ".empty_level"}, 128'(level), 128'(0));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, time %0t limit 500000", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      ibus_ack = 1'b0; cnt_done = 1'b0; ctrl_pc_en = 1'b0; wen0 = 1'b0; arm = 1'b0;
      abort = 1'b0; trig_en = 1'b0; rd_ready = 1'b0; ibus_rdt = 32'h0; ibus_adr = 32'h0;
      trig_pc = 32'h0; wdata0 = '0; rd_addr = 5'd0; post_cnt = '0;
      mq.delete();
      m_state = S_IDLE; m_mode = 1'b0; m_trig = 1'b0; m_ovf = 1'b0;
      m_tpc = 32'h0; m_pc = RPC; m_post = 0; m_cnt = 0;
      repeat (2) @(negedge clk);
      check_status("reset");
      check("reset.data", 128'(rd_data), 128'(0));
      rst_n = 1'b1;

      // Commit while IDLE is discarded
      retire(32'h13, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0);
      check_status("idle_commit");

      // Fill mode, three ADDI x5
      do_arm(1'b0, 32'h0, 0);
      for (int i = 1; i <= 3; i++) begin
         retire(addi(5'd5, 12'(i)), 5'd5, 1'b1, 32'(i), m_pc + 32'd4, 1'b0);
         check_status("fill3");
      end
      drain("fill3");

      // Fill until full: STOP after 4th push, later commits discarded
      do_abort();
      retire(32'h13, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0);
      check_status("stop_commit");
      do_arm(1'b0, 32'h0, 0);
      for (int i = 0; i < 6; i++) begin
         retire(addi(5'(i + 1), 12'(i * 7)), 5'(i + 1), 1'b1, $urandom, m_pc + 32'd4, 1'b0);
         check_status("fill_full");
      end
      drain("fill_full");

      // Store, branch and write to x0: rd_we clear
      do_arm(1'b0, 32'h0, 0);
      retire(32'h00112423, 5'd8, 1'b0, 32'h0, m_pc + 32'd4, 1'b0);
      retire(32'h00000463, 5'd8, 1'b0, 32'h0, m_pc + 32'd8, 1'b0);
      retire(32'h00500013, 5'd0, 1'b1, 32'h5, m_pc + 32'd4, 1'b0);
      check_status("nowe");
      drain("nowe");

      // Triggered capture, trigger at 0x20 with one post record
      do_abort();
      retire(32'h13, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0);
      do_arm(1'b1, 32'h20, 1);
      for (int i = 0; i <= 16; i++) begin
         retire(addi(5'd6, 12'(i)), 5'd6, 1'b1, $urandom, m_pc + 32'd4, 1'b0);
         check_status("trig");
      end
      check("trig.oldest_pc", 128'(rd_data[31:0]), 128'(32'h18));
      drain("trig");

      // Full in triggered RUN: pop and commit together keeps level and no overflow
      do_abort();
      do_arm(1'b1, 32'hFFFF_FFF0, 0);
      for (int i = 0; i < 4; i++)
         retire(addi(5'd7, 12'(i)), 5'd7, 1'b1, $urandom, m_pc + 32'd4, 1'b0);
      check_status("full_trig");
      retire(addi(5'd7, 12'd9), 5'd7, 1'b1, $urandom, m_pc + 32'd4, 1'b1);
      check_status("pop_push");
      retire(addi(5'd7, 12'd10), 5'd7, 1'b1, $urandom, m_pc + 32'd4, 1'b0);
      check_status("overwrite");
      drain("overwrite");

      // Asynchronous reset in POST with three records held
      do_arm(1'b1, m_pc, 3);
      for (int i = 0; i < 3; i++)
         retire(addi(5'd9, 12'(i)), 5'd9, 1'b1, $urandom, m_pc + 32'd4, 1'b0);
      check_status("post3");
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      mq.delete();
      m_state = S_IDLE; m_trig = 1'b0; m_ovf = 1'b0; m_pc = RPC;
      check_status("async_rst");
      check("async_rst.data", 128'(rd_data), 128'(0));
      @(negedge clk);
      rst_n = 1'b1;
      do_arm(1'b0, 32'h0, 0);
      retire(addi(5'd3, 12'd42), 5'd3, 1'b1, 32'd42, m_pc + 32'd4, 1'b0);
      check_status("after_rst");
      check("after_rst.pc", 128'(rd_data[31:0]), 128'(RPC));
      drain("after_rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
